// File: rtl/mul_issue_stage.sv
// Issue queue + launch/capture FSM feeding the Booth multiplier; result lands in the wb slot one lap after launch, and the FSM holds in S_RUN while the wb slot is blocked.
// Encodings: mul_ops_e MUL_=0 MULH=1 MULHSU=2 MULHU=3; fu_state_e FREE=0. Optional MUL_ZERO_SKIP_EN retires zero-operand ops without the unit.
module mul_issue_stage #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int TAG_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clk_en_i,
  input  logic             flush_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [1:0]       req_op_i,
  input  logic [XLEN-1:0]  req_rs1_i,
  input  logic [XLEN-1:0]  req_rs2_i,
  input  logic [TAG_W-1:0] req_tag_i,
  output logic [XLEN-1:0]  mul_multiplier_o,
  output logic [XLEN-1:0]  mul_multiplicand_o,
  output logic [1:0]       mul_operation_o,
  input  logic [XLEN-1:0]  mul_result_i,
  input  logic [1:0]       mul_fu_state_i,
  output logic             wb_valid_o,
  input  logic             wb_ready_i,
  output logic [XLEN-1:0]  wb_result_o,
  output logic [TAG_W-1:0] wb_tag_o,
  output logic             busy_o
);
  localparam logic [1:0] MUL_OP  = 2'd0;
  localparam logic [1:0] FU_FREE = 2'd0;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {S_IDLE, S_RUN} state_e;

  logic [1:0]       op_q  [DEPTH];
  logic [XLEN-1:0]  rs1_q [DEPTH];
  logic [XLEN-1:0]  rs2_q [DEPTH];
  logic [TAG_W-1:0] tag_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             empty, full, push, pop;

  state_e           state_q, state_d;
  logic             capture, wb_free, fu_free;
  logic [XLEN-1:0]  cap_result;
  logic             wb_valid_q;
  logic [XLEN-1:0]  wb_result_q;
  logic [TAG_W-1:0] wb_tag_q;

  assign empty       = (cnt_q == '0);
  assign full        = (cnt_q == CNT_W'(DEPTH));
  assign req_ready_o = !full && !flush_i;
  assign push        = req_valid_i && req_ready_o;
  assign pop         = capture;

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      op_q[wr_ptr_q]  <= req_op_i;
      rs1_q[wr_ptr_q] <= req_rs1_i;
      rs2_q[wr_ptr_q] <= req_rs2_i;
      tag_q[wr_ptr_q] <= req_tag_i;
    end
  end

  // Head stays put until capture pops it, so the unit sees stable operands across relaunches.
  assign mul_multiplier_o   = empty ? '0 : rs1_q[rd_ptr_q];
  assign mul_multiplicand_o = empty ? '0 : rs2_q[rd_ptr_q];
  assign mul_operation_o    = empty ? MUL_OP : op_q[rd_ptr_q];

  assign wb_free = !wb_valid_q || wb_ready_i;
  assign fu_free = (mul_fu_state_i == FU_FREE);

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    capture    = 1'b0;
    cap_result = mul_result_i;
    case (state_q)
      S_IDLE: begin
`ifdef MUL_ZERO_SKIP_EN
        if (!empty && wb_free &&
            (mul_multiplier_o == '0 || mul_multiplicand_o == '0)) begin
          capture    = 1'b1;
          cap_result = '0;
        end else
`endif
        if (clk_en_i && !empty && fu_free) state_d = S_RUN;
      end
      S_RUN: begin
        // Blocked slot: stay; the unit relaunches the same head and we retry next FREE.
        if (clk_en_i && fu_free && wb_free) begin
          capture = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (flush_i) begin
      state_d = S_IDLE;
      capture = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wb_valid_q  <= 1'b0;
      wb_result_q <= '0;
      wb_tag_q    <= '0;
    end else if (flush_i) begin
      wb_valid_q <= 1'b0;
    end else if (capture) begin
      wb_valid_q  <= 1'b1;
      wb_result_q <= cap_result;
      wb_tag_q    <= tag_q[rd_ptr_q];
    end else if (wb_valid_q && wb_ready_i) begin
      wb_valid_q <= 1'b0;
    end
  end

  assign wb_valid_o  = wb_valid_q;
  assign wb_result_o = wb_result_q;
  assign wb_tag_o    = wb_tag_q;
  assign busy_o      = !empty || (state_q != S_IDLE);
endmodule
